// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared constants and types for the MAC pipe scheduler
package mac_sched_pkg;
   localparam int REQ_FMA = 0;
   localparam int REQ_MUL = 1;
   localparam int MAX_LAT = 8;
   localparam int DEF_TAG = 4;
   typedef struct packed {
      logic               valid;
      logic               src;
      logic [DEF_TAG-1:0] tag;
   } stage_t;
endpackage

// File: rtl/mac_rr_arb2.sv
// mac_rr_arb2: two-input round-robin arbiter with hold enable
module mac_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       sel
);
   logic ptr;
   // grant the lone requester, or the pointer's port when both ask
   always_comb begin
      gnt = ~en ? 2'b00 : (&req) ? (ptr ? 2'b10 : 2'b01) : req;
      sel = gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : ptr;
   end
   // pointer moves to the port that lost (or did not ask) after any grant
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= 1'b0;
      else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/mac_pipe_scheduler.sv
// mac_pipe_scheduler: shares one pipelined multiplier between FMA and MUL issue
module mac_pipe_scheduler
   import mac_sched_pkg::*;
#(
   parameter int PARM_LAT = 3,
   parameter int PARM_TAG = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [1:0]          req_valid_i,
   input  logic [PARM_TAG-1:0] req_tag0_i,
   input  logic [PARM_TAG-1:0] req_tag1_i,
   output logic [1:0]          req_ready_o,
   input  logic                flush_i,
   output logic                opsel_o,
   output logic                pipe_en_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic                res_src_o,
   output logic [PARM_TAG-1:0] res_tag_o,
   output logic [3:0]          inflight_o,
   output logic                busy_o
);
   typedef struct packed {
      logic                valid;
      logic                src;
      logic [PARM_TAG-1:0] tag;
   } stg_t;

   if (PARM_LAT < 1 || PARM_LAT > MAX_LAT) begin : g_bad_lat
      $error("PARM_LAT out of range");
   end

   stg_t       stg [PARM_LAT];
   logic [1:0] gnt;
   logic       acc;

   assign pipe_en_o   = ~(stg[PARM_LAT-1].valid & ~res_ready_i);
   assign req_ready_o = gnt;
   assign acc         = |gnt;
   assign res_valid_o = stg[PARM_LAT-1].valid;
   assign res_src_o   = stg[PARM_LAT-1].src;
   assign res_tag_o   = stg[PARM_LAT-1].tag;
   assign busy_o      = |inflight_o;

   mac_rr_arb2 u_arb (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (pipe_en_o & ~flush_i),
      .req   (req_valid_i),
      .gnt   (gnt),
      .sel   (opsel_o)
   );

   // stage chain: flush clears valids even when stalled, otherwise shift on enable
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         for (int n = 0; n < PARM_LAT; n++) stg[n] <= '0;
      end else if (flush_i) begin
         for (int n = 0; n < PARM_LAT; n++) stg[n].valid <= 1'b0;
      end else if (pipe_en_o) begin
         stg[0] <= '{valid: acc, src: gnt[REQ_MUL],
                     tag: gnt[REQ_MUL] ? req_tag1_i : req_tag0_i};
         for (int n = 1; n < PARM_LAT; n++) stg[n] <= stg[n-1];
      end

   // occupancy is the popcount of stage valid bits
   always_comb begin
      inflight_o = '0;
      for (int n = 0; n < PARM_LAT; n++) inflight_o = inflight_o + 4'(stg[n].valid);
   end
endmodule

// File: tb/tb_mac_pipe_scheduler.sv
// tb_mac_pipe_scheduler: directed checks of arbitration, stall, flush and reset
module tb_mac_pipe_scheduler;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid, req_ready;
   logic [3:0] tag0, tag1, res_tag, inflight;
   logic       flush, opsel, pipe_en, res_valid, res_ready, res_src, busy;
   logic [1:0] req_valid1, req_ready1;
   logic [3:0] tag1_1, res_tag1, inflight1;
   logic       opsel1, pipe_en1, res_valid1, res_ready1, res_src1, busy1;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   mac_pipe_scheduler #(.PARM_LAT(3), .PARM_TAG(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_tag0_i(tag0),
      .req_tag1_i(tag1), .req_ready_o(req_ready), .flush_i(flush), .opsel_o(opsel),
      .pipe_en_o(pipe_en), .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_src_o(res_src), .res_tag_o(res_tag), .inflight_o(inflight), .busy_o(busy)
   );

   mac_pipe_scheduler #(.PARM_LAT(1), .PARM_TAG(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid1), .req_tag0_i(4'h0),
      .req_tag1_i(tag1_1), .req_ready_o(req_ready1), .flush_i(1'b0), .opsel_o(opsel1),
      .pipe_en_o(pipe_en1), .res_valid_o(res_valid1), .res_ready_i(res_ready1),
      .res_src_o(res_src1), .res_tag_o(res_tag1), .inflight_o(inflight1), .busy_o(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      req_valid = 2'b00; tag0 = 4'h0; tag1 = 4'h0; flush = 1'b0; res_ready = 1'b1;
      req_valid1 = 2'b00; tag1_1 = 4'h0; res_ready1 = 1'b1;
      rst_n = 1'b1;
      #2;
      do_reset();
      // reset state
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pipe_en", 32'(pipe_en), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_opsel", 32'(opsel), 32'd0);
      // single FMA issue, latency 3
      req_valid = 2'b01; tag0 = 4'h5;
      #1;
      chk("t1_ready", 32'(req_ready), 32'd1);
      chk("t1_opsel", 32'(opsel), 32'd0);
      step();
      req_valid = 2'b00;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk($sformatf("t1_valid_c%0d", c), 32'(res_valid), 32'(c == 3));
         chk($sformatf("t1_inflight_c%0d", c), 32'(inflight), 32'(c < 4));
         if (c == 3) begin
            chk("t1_src", 32'(res_src), 32'd0);
            chk("t1_tag", 32'(res_tag), 32'd5);
         end
         step();
      end
      // both requesters every cycle: alternating grants, in-order results
      do_reset();
      for (int c = 0; c < 9; c++) begin
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         tag0 = 4'(c); tag1 = 4'(c);
         #1;
         if (c < 6) chk($sformatf("t2_gnt_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("t2_valid_c%0d", c), 32'(res_valid), 32'(c >= 3));
         if (c >= 3) begin
            chk($sformatf("t2_src_c%0d", c), 32'(res_src), 32'((c - 3) % 2));
            chk($sformatf("t2_tag_c%0d", c), 32'(res_tag), 32'(c - 3));
         end
         step();
      end
      // stall with three in flight, then drain
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req_valid = 2'b10; tag1 = 4'(4'hA + c);
         #1;
         chk($sformatf("t3_gnt_c%0d", c), 32'(req_ready), 32'd2);
         step();
      end
      req_valid = 2'b01; res_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("t3_pipe_en_s%0d", c), 32'(pipe_en), 32'd0);
         chk($sformatf("t3_ready_s%0d", c), 32'(req_ready), 32'd0);
         chk($sformatf("t3_tag_s%0d", c), 32'(res_tag), 32'hA);
         chk($sformatf("t3_inflight_s%0d", c), 32'(inflight), 32'd3);
         step();
      end
      req_valid = 2'b00; res_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("t3_dvalid_d%0d", c), 32'(res_valid), 32'(c < 3));
         if (c < 3) chk($sformatf("t3_dtag_d%0d", c), 32'(res_tag), 32'(4'hA + c));
         step();
      end
      // flush while stalled with both requesting
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req_valid = (c < 2) ? 2'b01 : 2'b00; tag0 = 4'(c + 1);
         step();
      end
      res_ready = 1'b0;
      #1;
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_inflight", 32'(inflight), 32'd2);
      step();
      req_valid = 2'b11; flush = 1'b1;
      #1;
      chk("t4_flush_ready", 32'(req_ready), 32'd0);
      chk("t4_flush_opsel", 32'(opsel), 32'd1);
      step();
      flush = 1'b0; res_ready = 1'b1;
      #1;
      chk("t4_post_valid", 32'(res_valid), 32'd0);
      chk("t4_post_inflight", 32'(inflight), 32'd0);
      chk("t4_post_ptr_gnt", 32'(req_ready), 32'd2);
      step();
      // asynchronous reset mid-stream
      for (int c = 0; c < 3; c++) begin
         req_valid = 2'b01; tag0 = 4'(c);
         step();
      end
      req_valid = 2'b00;
      #1;
      chk("t5_pre_valid", 32'(res_valid), 32'd1);
      chk("t5_pre_busy", 32'(busy), 32'd1);
      chk("t5_pre_ptr", 32'(opsel), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(res_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ptr", 32'(opsel), 32'd0);
      #1;
      rst_n = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("t5_first_gnt", 32'(req_ready), 32'd1);
      step();
      req_valid = 2'b00;
      step();
      // single-stage pipe: continuous MUL issue with toggling consumer
      for (int c = 0; c < 5; c++) begin
         req_valid1 = 2'b10; tag1_1 = 4'(c);
         res_ready1 = (c == 2) ? 1'b0 : 1'b1;
         #1;
         chk($sformatf("t6_valid_c%0d", c), 32'(res_valid1), 32'(c >= 1));
         chk($sformatf("t6_ready_c%0d", c), 32'(req_ready1), (c == 2) ? 32'd0 : 32'd2);
         if (c >= 1) begin
            chk($sformatf("t6_tag_c%0d", c), 32'(res_tag1), (c == 4) ? 32'd3 : (c == 1) ? 32'd0 : 32'd1);
            chk($sformatf("t6_src_c%0d", c), 32'(res_src1), 32'd1);
         end
         step();
      end
      req_valid1 = 2'b00;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
